// File: rtl/gpio_irq_bank.sv
// Multi-bank GPIO controller: 16-bit register lanes, 2-flop input sync, edge-detect interrupts.
// Optional per-pin input debounce is compiled in with `define GPIO_DEBOUNCE_EN.
module gpio_irq_bank #(
    parameter int NUM_GPIO        = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [4:0]          Addr,
    output logic [15:0]         DataRd,
    input  logic [15:0]         DataWr,
    input  logic                En,
    input  logic                Rd,
    input  logic                Wr,
    inout  wire  [NUM_GPIO-1:0] P,
    output logic                Irq
);
    localparam int N = NUM_GPIO;
    localparam int B = (NUM_GPIO + 15) / 16;

    logic [2:0]   reg_idx;
    logic [1:0]   bank;
    logic         bank_ok;
    logic         wr_en;
    logic [N-1:0] wmask;
    logic [N-1:0] wdata;

    logic [N-1:0] ddr;
    logic [N-1:0] data_out;
    logic [N-1:0] rise_en;
    logic [N-1:0] fall_en;
    logic [N-1:0] ien;
    logic [N-1:0] pend;
    logic [N-1:0] s1;
    logic [N-1:0] s2;
    logic [N-1:0] f;
    logic [N-1:0] f_prev;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] clr;
    logic [N-1:0] rd_val;

    function automatic logic [N-1:0] merge(input logic [N-1:0] old, input logic [N-1:0] val,
                                           input logic [N-1:0] mask);
        return (old & ~mask) | (val & mask);
    endfunction

    function automatic logic [15:0] lane(input logic [N-1:0] v, input logic [1:0] b);
        logic [63:0] w;
        w = 64'(v);
        return w[{b, 4'b0000} +: 16];
    endfunction

    assign reg_idx = Addr[4:2];
    assign bank    = Addr[1:0];
    assign bank_ok = ({30'd0, bank} < B);
    assign wr_en   = En & Wr & bank_ok;
    // Lane masks are truncated to the pin count, so bits past NUM_GPIO never reach a register.
    assign wmask   = N'(64'hFFFF << {bank, 4'b0000});
    assign wdata   = N'({48'd0, DataWr} << {bank, 4'b0000});

    for (genvar i = 0; i < N; i++) begin : g_pin
        assign P[i] = ddr[i] ? data_out[i] : 1'bz;
    end

    assign rise = f & ~f_prev & rise_en;
    assign fall = ~f & f_prev & fall_en;
    assign clr  = (wr_en && reg_idx == 3'd6) ? (wdata & wmask) : '0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ddr      <= '0;
            data_out <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
            ien      <= '0;
            pend     <= '0;
            s1       <= '0;
            s2       <= '0;
            f_prev   <= '0;
        end else begin
            s1     <= P;
            s2     <= s1;
            f_prev <= f;
            // A freshly detected edge survives a same-cycle write-1-to-clear.
            pend   <= (pend & ~clr) | rise | fall;
            if (wr_en) begin
                case (reg_idx)
                    3'd0:    ddr      <= merge(ddr, wdata, wmask);
                    3'd1:    data_out <= merge(data_out, wdata, wmask);
                    3'd3:    rise_en  <= merge(rise_en, wdata, wmask);
                    3'd4:    fall_en  <= merge(fall_en, wdata, wmask);
                    3'd5:    ien      <= merge(ien, wdata, wmask);
                    3'd7:    data_out <= data_out ^ (wdata & wmask);
                    default: ;
                endcase
            end
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt [N];

    // F follows S2 only after S2 has differed from it for DEBOUNCE_CYCLES consecutive edges.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < N; i++) begin
            if (Reset) begin
                cnt[i] <= '0;
                f[i]   <= 1'b0;
            end else if (s2[i] == f[i]) begin
                cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
                f[i]   <= s2[i];
                cnt[i] <= '0;
            end else begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end
`else
    assign f = s2;
`endif

    always_comb begin
        rd_val = '0;
        case (reg_idx)
            3'd0:    rd_val = ddr;
            3'd1:    rd_val = f;
            3'd2:    rd_val = data_out;
            3'd3:    rd_val = rise_en;
            3'd4:    rd_val = fall_en;
            3'd5:    rd_val = ien;
            3'd6:    rd_val = pend;
            default: rd_val = '0;
        endcase
    end

    assign DataRd = (En && Rd && bank_ok) ? lane(rd_val, bank) : 16'h0000;
    assign Irq    = |(pend & ien);

endmodule

// File: doc/gpio_irq_bank.md
# gpio_irq_bank

Parametrised multi-bank GPIO controller, next generation of the 16-pin GPIO block on the 16-bit peripheral bus. Supports 1–64 pins in 16-bit banks. Per-pin direction, output data and toggle-write are provided. Inputs pass through a 2-flop synchroniser, with optional debounce, and feed per-pin rising/falling edge detection, sticky write-1-to-clear pending bits, and one level-high interrupt output to the host.

## Interface
- NUM_GPIO, 16: pin count, 1–64; banks B = (NUM_GPIO+15)/16
- DEBOUNCE_CYCLES, 4: stable-cycle count for debounce, ≥1; used only with GPIO_DEBOUNCE_EN
- Clk  in  1  sole clock, rising edge
- Reset  in  1  synchronous, active-high reset
- Addr  in  5  register select Addr[4:2], bank select Addr[1:0]
- DataRd  out  16  read data, combinational
- DataWr  in  16  write data
- En  in  1  block select
- Rd  in  1  read strobe
- Wr  in  1  write strobe; a write occurs on the Clk edge where En & Wr
- P  inout  NUM_GPIO  pins; driven from DataReg where DdrReg=1, else Z
- Irq  out  1  |(PendReg & IenReg)

## Operation
- Register index = Addr[4:2], bank b = Addr[1:0]. Each access covers pins b*16 .. b*16+15. Bits at or above NUM_GPIO are ignored on write and read as 0.
- Register 0, DDR: read/write. 1 = output.
- Register 1, DATA: write sets DataReg. Read returns the filtered input value F.
- Register 2, OUT: read-only readback of DataReg.
- Register 3, RISE: read/write rising-edge enable.
- Register 4, FALL: read/write falling-edge enable.
- Register 5, IEN: read/write interrupt enable.
- Register 6, PEND: read returns PendReg. Write-1-to-clear.
- Register 7, TOGGLE: write XORs DataWr into DataReg. Reads 0.
- Bank b ≥ B: writes ignored, reads 0.
- DataRd = 0 unless En & Rd.
- Synchroniser S1 ← P, then S2 ← S1. Filtered value F is equal to S2, except with debounce enabled. Previous-value register Fp ← F.
- Edge detect: rise = F & ~Fp & RISE; fall = ~F & Fp & FALL.
- Pending update: PendReg ← (PendReg & ~clr) | rise | fall. Detection wins over a same-cycle W1C clear of that bit.
- PendReg bits set while IEN=0 stay set. Setting IEN afterwards raises Irq.
- Pin behaviour is independent of DDR: output pins are also sampled, so driven outputs can raise edges (loopback).
- Reset: DdrReg, DataReg, RISE, FALL, IEN, PendReg, S1, S2, F, Fp and debounce counters all 0. Result: all pins Z and Irq=0.
- Reset asserted together with Wr: reset wins and the write is discarded.

## Timing
- Register writes take effect at the Clk edge of the strobe. Readback and P drive reflect the new value after that edge.
- Reads are combinational in the same cycle.
- Pin change sampled at edge k: S1 at edge k, S2 at edge k+1, DATA read and F updated after edge k+1.
- Without debounce, PendReg and Irq are set after edge k+2.
- A pulse shorter than one Clk period may be missed. This is not an error.
- Irq is combinational from registers. It falls the cycle after the W1C edge unless a new edge is detected in the same cycle.

## Configuration
- GPIO_DEBOUNCE_EN defined: each pin has a counter of width clog2(DEBOUNCE_CYCLES+1).
  - Counter resets to 0 whenever S2 == F.
  - Counter increments while S2 != F.
  - When it reaches DEBOUNCE_CYCLES, F ← S2 and the counter clears.
  - Added latency: DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES are suppressed.
- Undefined: F = S2 combinationally, no counters, and DEBOUNCE_CYCLES is ignored.

## Test plan
- Reset, then read all registers in all banks → all 0. Irq=0. P all Z.
- NUM_GPIO=20:
  - Write DDR bank1 = 0xFFFF, then DATA bank1 = 0x000A → P[19:16]=0xA, DDR bank1 reads 0x000F.
  - Write TOGGLE bank1 = 0x0003 → OUT bank1 = 0x0009.
- RISE bank0 = 0x0001, IEN = 0x0001. Drive P[0] 0→1 at edge k → PEND bank0 = 0x0001 and Irq=1 after edge k+2 (no debounce).
- Write PEND = 0x0001 in the same cycle a new rising edge on P[0] is detected → PEND stays 0x0001 and Irq stays 1.
- Debounce enabled, DEBOUNCE_CYCLES=4:
  - 3-cycle high glitch on P[1] with RISE enabled → no pending.
  - 6-cycle high on P[1] → PEND bit1 set, 4 cycles later than without the macro.
- Assert Reset mid-sequence with PEND=0xFFFF, DDR=0xFFFF → next cycle all registers 0, Irq=0, P Z.
